// File: rtl/trsq8_peri_pkg.sv
// TRSQ8 peripheral bus address map, slave indices and return-select encoding.
// Shared by the arbiter and any bus bridge that needs the same decode.
package trsq8_peri_pkg;

    localparam int unsigned NumSlaves = 4;

    localparam logic [7:0] RamBase  = 8'h00;
    localparam logic [7:0] RamLast  = 8'h7F;
    localparam logic [7:0] SpiBase  = 8'h80;
    localparam logic [7:0] SpiLast  = 8'h83;
    localparam logic [7:0] GpioBase = 8'h84;
    localparam logic [7:0] GpioLast = 8'h87;
    localparam logic [7:0] IicBase  = 8'h90;
    localparam logic [7:0] IicLast  = 8'h93;

    // Slave index doubles as the bit position in the one-hot select.
    typedef enum logic [2:0] {
        SelRam  = 3'd0,
        SelSpi  = 3'd1,
        SelGpio = 3'd2,
        SelIic  = 3'd3,
        SelErr  = 3'd4
    } rsel_e;

    function automatic logic in_range(input logic [7:0] addr,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic rsel_e sel_to_idx(input logic [NumSlaves-1:0] sel);
        rsel_e idx;
        case (sel)
            4'b0001: idx = SelRam;
            4'b0010: idx = SelSpi;
            4'b0100: idx = SelGpio;
            4'b1000: idx = SelIic;
            default: idx = SelErr;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/peri_bus_arbiter_if.sv
// Signal bundle joining the CPU, the secondary master and the four peripheral
// slaves to the arbiter.
interface peri_bus_arbiter_if;

    logic [7:0] m0_addr;
    logic [7:0] m0_wdata;
    logic       m0_wr_en;
    logic       m0_rd_en;
    logic [7:0] m0_rdata;
    logic       m0_rvalid;

    logic [7:0] m1_addr;
    logic [7:0] m1_wdata;
    logic       m1_req;
    logic       m1_we;
    logic       m1_gnt;
    logic [7:0] m1_rdata;
    logic       m1_rvalid;

    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_wr_en;
    logic       s_rd_en;
    logic [3:0] s_sel;
    logic [7:0] s_rdata_ram;
    logic [7:0] s_rdata_spi;
    logic [7:0] s_rdata_gpio;
    logic [7:0] s_rdata_iic;

    logic       dec_err;
    logic       m1_starve;

    // Arbiter side: it is the slave of both masters and drives the slave bus.
    modport slave (
        input  m0_addr, m0_wdata, m0_wr_en, m0_rd_en,
        input  m1_addr, m1_wdata, m1_req, m1_we,
        input  s_rdata_ram, s_rdata_spi, s_rdata_gpio, s_rdata_iic,
        output m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output s_addr, s_wdata, s_wr_en, s_rd_en, s_sel,
        output dec_err, m1_starve
    );

    modport master (
        output m0_addr, m0_wdata, m0_wr_en, m0_rd_en,
        output m1_addr, m1_wdata, m1_req, m1_we,
        output s_rdata_ram, s_rdata_spi, s_rdata_gpio, s_rdata_iic,
        input  m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  s_addr, s_wdata, s_wr_en, s_rd_en, s_sel,
        input  dec_err, m1_starve
    );

endinterface

// File: rtl/peri_addr_decode.sv
// Combinational TRSQ8 peripheral address decoder: one-hot slave select plus
// an error flag for addresses that hit no slave.
module peri_addr_decode
    import trsq8_peri_pkg::*;
(
    input  logic [7:0]           addr_i,
    output logic [NumSlaves-1:0] sel_o,
    output logic                 err_o
);

    assign sel_o = {in_range(addr_i, IicBase,  IicLast),
                    in_range(addr_i, GpioBase, GpioLast),
                    in_range(addr_i, SpiBase,  SpiLast),
                    in_range(addr_i, RamBase,  RamLast)};

    assign err_o = ~|sel_o;

endmodule

// File: rtl/peri_bus_arbiter.sv
// Two-master, four-slave TRSQ8 peripheral bus arbiter with fixed CPU priority,
// registered read-return steering and a secondary-master starvation monitor.
module peri_bus_arbiter
    import trsq8_peri_pkg::*;
#(
    parameter logic [7:0] STARVE_MAX = 8'd64,
    parameter logic [7:0] ERR_RDATA  = 8'hFF
) (
    input logic               clk,
    input logic               reset_n,
    peri_bus_arbiter_if.slave bus_io
);

    logic                 m0_act;
    logic                 m0_rd;
    logic                 m1_gnt;
    logic                 m1_rd;
    logic                 bus_act;
    logic                 rd_issue;
    logic [7:0]           bus_addr;
    logic [NumSlaves-1:0] dec_sel;
    logic                 dec_err_raw;

    logic                 owner_q, owner_d;
    logic                 rpend_q, rpend_d;
    rsel_e                rsel_q, rsel_d;
    logic [7:0]           starve_cnt_q, starve_cnt_d;
    logic                 m1_wait;
    logic                 starve_hit;
    logic [7:0]           ret_data;

    assign m0_act   = bus_io.m0_wr_en | bus_io.m0_rd_en;
    assign m1_gnt   = bus_io.m1_req & ~m0_act;
    // A double strobe from the CPU is treated as a write.
    assign m0_rd    = bus_io.m0_rd_en & ~bus_io.m0_wr_en;
    assign m1_rd    = m1_gnt & ~bus_io.m1_we;
    assign bus_act  = m0_act | m1_gnt;
    assign rd_issue = m0_rd | m1_rd;

    always_comb begin
        bus_addr        = '0;
        bus_io.s_wdata  = '0;
        bus_io.s_wr_en  = 1'b0;
        bus_io.s_rd_en  = 1'b0;
        if (m0_act) begin
            bus_addr        = bus_io.m0_addr;
            bus_io.s_wdata  = bus_io.m0_wdata;
            bus_io.s_wr_en  = bus_io.m0_wr_en;
            bus_io.s_rd_en  = m0_rd;
        end else if (m1_gnt) begin
            bus_addr        = bus_io.m1_addr;
            bus_io.s_wdata  = bus_io.m1_wdata;
            bus_io.s_wr_en  = bus_io.m1_we;
            bus_io.s_rd_en  = ~bus_io.m1_we;
        end
    end

    peri_addr_decode u_decode (
        .addr_i (bus_addr),
        .sel_o  (dec_sel),
        .err_o  (dec_err_raw)
    );

    assign bus_io.s_addr  = bus_addr;
    assign bus_io.s_sel   = bus_act ? dec_sel : '0;
    assign bus_io.dec_err = (bus_act & dec_err_raw) | (bus_io.m0_wr_en & bus_io.m0_rd_en);
    assign bus_io.m1_gnt  = m1_gnt;

    // Read issue captures who asked and where; the return is muxed next cycle.
    always_comb begin
        rpend_d = rd_issue;
        owner_d = owner_q;
        rsel_d  = rsel_q;
        if (rd_issue) begin
            owner_d = ~m0_act;
            rsel_d  = sel_to_idx(dec_sel);
        end
    end

    assign m1_wait    = bus_io.m1_req & ~m1_gnt;
    assign starve_hit = m1_wait & (starve_cnt_q == STARVE_MAX - 8'd1);

    always_comb begin
        starve_cnt_d = starve_cnt_q + 8'd1;
        if (!m1_wait || starve_hit) begin
            starve_cnt_d = '0;
        end
    end

    assign bus_io.m1_starve = starve_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpend_q      <= 1'b0;
            owner_q      <= 1'b0;
            rsel_q       <= SelRam;
            starve_cnt_q <= '0;
        end else begin
            rpend_q      <= rpend_d;
            owner_q      <= owner_d;
            rsel_q       <= rsel_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        case (rsel_q)
            SelRam:  ret_data = bus_io.s_rdata_ram;
            SelSpi:  ret_data = bus_io.s_rdata_spi;
            SelGpio: ret_data = bus_io.s_rdata_gpio;
            SelIic:  ret_data = bus_io.s_rdata_iic;
            default: ret_data = ERR_RDATA;
        endcase
    end

    assign bus_io.m0_rvalid = rpend_q & ~owner_q;
    assign bus_io.m1_rvalid = rpend_q & owner_q;
    assign bus_io.m0_rdata  = bus_io.m0_rvalid ? ret_data : '0;
    assign bus_io.m1_rdata  = bus_io.m1_rvalid ? ret_data : '0;

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Self-checking bench for peri_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a cycle-level reference model.
`timescale 1ns/1ps
module tb_peri_bus_arbiter;

    localparam logic [7:0] StarveMax = 8'd64;
    localparam logic [7:0] ErrRdata  = 8'hFF;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    peri_bus_arbiter_if bus ();

    peri_bus_arbiter #(
        .STARVE_MAX (StarveMax),
        .ERR_RDATA  (ErrRdata)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mdl_pend;
    bit mdl_owner;
    int mdl_slave;
    int mdl_wait;

    function automatic int ref_slave(input logic [7:0] a);
        if (a < 8'h80) return 0;
        if (a >= 8'h80 && a <= 8'h83) return 1;
        if (a >= 8'h84 && a <= 8'h87) return 2;
        if (a >= 8'h90 && a <= 8'h93) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] slave_data(input int s);
        case (s)
            0: return bus.s_rdata_ram;
            1: return bus.s_rdata_spi;
            2: return bus.s_rdata_gpio;
            3: return bus.s_rdata_iic;
            default: return ErrRdata;
        endcase
    endfunction

    always @(negedge clk) begin : ref_model
        logic       m0_act, gnt, wr, rd, err, waiting, starve, m0v, m1v;
        logic [7:0] a, wd, m0d, m1d, data;
        logic [3:0] sel;
        int         s;
        if (!reset_n) begin
            mdl_pend = 1'b0;
            mdl_wait = 0;
        end
        m0_act = bus.m0_wr_en || bus.m0_rd_en;
        gnt    = bus.m1_req && !m0_act;
        a = 8'h00; wd = 8'h00; wr = 1'b0; rd = 1'b0; err = 1'b0; sel = 4'b0000;
        if (m0_act) begin
            a  = bus.m0_addr;
            wd = bus.m0_wdata;
            wr = bus.m0_wr_en;
            rd = bus.m0_rd_en && !bus.m0_wr_en;
        end else if (gnt) begin
            a  = bus.m1_addr;
            wd = bus.m1_wdata;
            wr = bus.m1_we;
            rd = !bus.m1_we;
        end
        s = ref_slave(a);
        if (m0_act || gnt) begin
            if (s >= 0) sel = 4'(1 << s);
            err = (s < 0) || (bus.m0_wr_en && bus.m0_rd_en);
        end
        data = slave_data(mdl_slave);
        m0v  = mdl_pend && !mdl_owner;
        m1v  = mdl_pend && mdl_owner;
        m0d  = m0v ? data : 8'h00;
        m1d  = m1v ? data : 8'h00;
        waiting = bus.m1_req && !gnt;
        starve  = waiting && (((mdl_wait + 1) % int'(StarveMax)) == 0);
        chk("model", {21'b0, bus.s_sel, bus.s_addr, bus.s_wdata, bus.s_wr_en, bus.s_rd_en,
                      bus.m1_gnt, bus.dec_err, bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid,
                      bus.m1_rdata, bus.m1_starve},
                     {21'b0, sel, a, wd, wr, rd, gnt, err, m0v, m0d, m1v, m1d, starve});
        if (reset_n) begin
            mdl_pend  = rd;
            mdl_owner = !m0_act;
            mdl_slave = s;
            mdl_wait  = waiting ? mdl_wait + 1 : 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.m0_wr_en = 1'b0; bus.m0_rd_en = 1'b0; bus.m0_addr = 8'h00; bus.m0_wdata = 8'h00;
        bus.m1_req   = 1'b0; bus.m1_we    = 1'b0; bus.m1_addr = 8'h00; bus.m1_wdata = 8'h00;
    endtask

    task automatic set_rdata(input logic [7:0] r, input logic [7:0] s_, input logic [7:0] g,
                             input logic [7:0] i);
        bus.s_rdata_ram = r; bus.s_rdata_spi = s_; bus.s_rdata_gpio = g; bus.s_rdata_iic = i;
    endtask

    typedef struct packed {
        logic       m0_wr;
        logic       m0_rd;
        logic [7:0] m0_addr;
        logic       m1_req;
        logic       m1_we;
        logic [7:0] m1_addr;
        logic [3:0] sel;
        logic [7:0] s_addr;
        logic       wr;
        logic       rd;
        logic       gnt;
        logic       err;
        logic       ret0;
        logic       ret1;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int first_pulse, second_pulse, n_pulse;
        logic prev_gnt;
        logic [3:0] r;

        reset_n = 1'b0;
        idle_inputs();
        set_rdata(8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        chk("reset outputs", {50'b0, bus.m0_rvalid, bus.m1_rvalid, bus.dec_err, bus.m1_starve,
                              bus.s_sel, bus.m0_rdata},
                             64'h0);
        chk("reset m1_rdata", 64'(bus.m1_rdata), 64'h0);
        #10;
        reset_n = 1'b1;
        tick();

        // ---------------- vector table ----------------
        vecs[0]  = '{1'b0, 1'b1, 8'h85, 1'b0, 1'b0, 8'h00, 4'b0100, 8'h85, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
        vecs[1]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[3]  = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 4'b0010, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        vecs[4]  = '{1'b0, 1'b1, 8'h87, 1'b0, 1'b0, 8'h00, 4'b0100, 8'h87, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
        vecs[5]  = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h88, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[6]  = '{1'b0, 1'b1, 8'h93, 1'b0, 1'b0, 8'h00, 4'b1000, 8'h93, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
        vecs[7]  = '{1'b0, 1'b1, 8'h94, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h94, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA0, 4'b0000, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h90, 4'b1000, 8'h90, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h8F, 1'b1, 1'b0, 8'h10, 4'b0000, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h84, 4'b0100, 8'h84, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        set_rdata(8'h11, 8'h22, 8'h5A, 8'h44);
        for (int i = 0; i < 14; i++) begin
            bus.m0_wr_en = vecs[i].m0_wr;  bus.m0_rd_en = vecs[i].m0_rd;
            bus.m0_addr  = vecs[i].m0_addr; bus.m0_wdata = 8'($urandom);
            bus.m1_req   = vecs[i].m1_req; bus.m1_we    = vecs[i].m1_we;
            bus.m1_addr  = vecs[i].m1_addr; bus.m1_wdata = 8'($urandom);
            settle();
            chk($sformatf("vec%0d issue", i),
                {46'b0, bus.s_sel, bus.s_addr, bus.s_wr_en, bus.s_rd_en, bus.m1_gnt, bus.dec_err},
                {46'b0, vecs[i].sel, vecs[i].s_addr, vecs[i].wr, vecs[i].rd, vecs[i].gnt,
                 vecs[i].err});
            tick();
            idle_inputs();
            settle();
            chk($sformatf("vec%0d return", i),
                {46'b0, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata},
                {46'b0, vecs[i].ret0, vecs[i].ret1, vecs[i].ret0 ? vecs[i].rdata : 8'h00,
                 vecs[i].ret1 ? vecs[i].rdata : 8'h00});
            tick();
        end

        // ---------------- collision: m1 held off by three m0 writes ----------------
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h10;
        for (int c = 0; c < 3; c++) begin
            bus.m0_wr_en = 1'b1; bus.m0_addr = 8'h81; bus.m0_wdata = 8'(c);
            settle();
            chk($sformatf("collision gnt low %0d", c), 64'(bus.m1_gnt), 64'h0);
            tick();
        end
        bus.m0_wr_en = 1'b0;
        settle();
        chk("collision gnt", {59'b0, bus.m1_gnt, bus.s_sel}, {59'b0, 1'b1, 4'b0001});
        tick();
        idle_inputs();
        bus.s_rdata_ram = 8'h3C;
        settle();
        chk("collision return", {47'b0, bus.m0_rvalid, bus.m1_rvalid, bus.m1_rdata},
                                {47'b0, 1'b0, 1'b1, 8'h3C});
        tick();

        // ---------------- pipelined reads, m0 then m1 ----------------
        bus.m0_rd_en = 1'b1; bus.m0_addr = 8'h90;
        bus.m1_req   = 1'b1; bus.m1_we   = 1'b0; bus.m1_addr = 8'h20;
        settle();
        chk("pipe issue0", {59'b0, bus.m1_gnt, bus.s_sel}, {59'b0, 1'b0, 4'b1000});
        tick();
        bus.m0_rd_en = 1'b0;
        bus.s_rdata_iic = 8'hC3;
        settle();
        chk("pipe issue1", {51'b0, bus.m1_gnt, bus.s_sel, bus.s_addr}, {51'b0, 1'b1, 4'b0001, 8'h20});
        chk("pipe ret0", {46'b0, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata},
                         {46'b0, 1'b1, 1'b0, 8'hC3, 8'h00});
        tick();
        idle_inputs();
        bus.s_rdata_ram = 8'h7E; bus.s_rdata_iic = 8'h00;
        settle();
        chk("pipe ret1", {46'b0, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata},
                         {46'b0, 1'b0, 1'b1, 8'h00, 8'h7E});
        tick();

        // ---------------- starvation ----------------
        first_pulse = -1; second_pulse = -1; n_pulse = 0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h10;
        for (int w = 1; w <= 130; w++) begin
            bus.m0_wr_en = w[0]; bus.m0_rd_en = ~w[0]; bus.m0_addr = 8'(w);
            settle();
            if (bus.m1_starve) begin
                n_pulse++;
                if (n_pulse == 1) first_pulse = w;
                if (n_pulse == 2) second_pulse = w;
            end
            tick();
        end
        chk("starve pulses", 64'(n_pulse), 64'd2);
        chk("starve first", 64'(first_pulse), 64'd64);
        chk("starve second", 64'(second_pulse), 64'd128);
        bus.m0_wr_en = 1'b0; bus.m0_rd_en = 1'b0;
        settle();
        chk("starve then gnt", {62'b0, bus.m1_gnt, bus.m1_starve}, {62'b0, 1'b1, 1'b0});
        tick();
        idle_inputs();
        tick();

        // ---------------- reset during m0 return cycle ----------------
        bus.m0_rd_en = 1'b1; bus.m0_addr = 8'h05; bus.s_rdata_ram = 8'hA5;
        settle();
        tick();
        idle_inputs();
        settle();
        chk("rst pre rvalid", {55'b0, bus.m0_rvalid, bus.m0_rdata}, {55'b0, 1'b1, 8'hA5});
        reset_n = 1'b0;
        #2;
        chk("rst drop rvalid", {55'b0, bus.m0_rvalid, bus.m0_rdata}, 64'h0);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            chk($sformatf("rst after %0d", k), {62'b0, bus.m0_rvalid, bus.m1_rvalid}, 64'h0);
        end
        tick();

        // ---------------- randomized run (model checks every cycle) ----------------
        for (int n = 0; n < 3000; n++) begin
            prev_gnt = bus.m1_req && !(bus.m0_wr_en || bus.m0_rd_en);
            r = 4'($urandom_range(0, 9));
            bus.m0_wr_en = (r == 4'd7) || (r == 4'd8) || (r == 4'd9);
            bus.m0_rd_en = (r >= 4'd4 && r <= 4'd6) || (r == 4'd9);
            bus.m0_addr  = rand_addr();
            bus.m0_wdata = 8'($urandom);
            if (!bus.m1_req || prev_gnt || $urandom_range(0, 15) == 0) begin
                bus.m1_req   = $urandom_range(0, 2) != 0;
                bus.m1_we    = 1'($urandom);
                bus.m1_addr  = rand_addr();
                bus.m1_wdata = 8'($urandom);
            end
            set_rdata(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 127));
            1: return 8'(8'h80 + $urandom_range(0, 7));
            2: return 8'(8'h90 + $urandom_range(0, 3));
            default: return 8'($urandom);
        endcase
    endfunction

endmodule

// File: doc/peri_bus_arbiter.md
# peri_bus_arbiter

Two-master, four-slave arbiter and address decoder for the TRSQ8 8-bit peripheral bus. It sits between the CPU (master 0) and a cycle-stealing secondary master (master 1, e.g. a DMA or debug engine) on one side, and RAM, SPI, GPIO and IIC on the other. It decodes per-slave selects and muxes registered slave read data back to whichever master issued the read. It replaces the shared, wired read-data net with an explicit, owned return path.

## Interface
Parameters:
- STARVE_MAX, 8'd64: master-1 wait cycles before `m1_starve` pulses.
- ERR_RDATA, 8'hFF: read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_addr / m0_wdata  in  8/8  CPU address and write data.
- m0_wr_en / m0_rd_en  in  1/1  CPU strobes, one cycle each; never stalled.
- m0_rdata / m0_rvalid  out  8/1  CPU read return.
- m1_addr / m1_wdata  in  8/8  secondary master address and write data.
- m1_req / m1_we  in  1/1  request held until granted; `m1_we`=1 for write.
- m1_gnt  out  1  access performed this cycle.
- m1_rdata / m1_rvalid  out  8/1  secondary read return.
- s_addr / s_wdata  out  8/8  slave address and write data.
- s_wr_en / s_rd_en  out  1/1  slave strobes.
- s_sel  out  4  one-hot select: [0] RAM, [1] SPI, [2] GPIO, [3] IIC.
- s_rdata_ram, s_rdata_spi, s_rdata_gpio, s_rdata_iic  in  8 each  slave read data, valid one cycle after `s_rd_en`.
- dec_err  out  1  one-cycle pulse on an access to an unmapped address.
- m1_starve  out  1  one-cycle pulse, see below.

## Operation
- Decode: 0x00–0x7F RAM, 0x80–0x83 SPI, 0x84–0x87 GPIO, 0x90–0x93 IIC. Any other address gives `s_sel`=0 and `dec_err`=1 in the access cycle.
- Priority is fixed: master 0 wins.
  - An m0 access occurs in any cycle with `m0_wr_en|m0_rd_en`.
  - Otherwise, if `m1_req`, m1 is granted: `m1_gnt`=1, bus driven from m1, `s_wr_en`=`m1_we`, `s_rd_en`=`~m1_we`.
  - Idle: the bus is driven with all strobes 0, `s_sel`=0 and `s_addr`/`s_wdata`=0.
- If m0 asserts both `m0_wr_en` and `m0_rd_en`, the cycle is a write; `dec_err` pulses and no read is returned.
- Read return pipeline: on a read access, register `owner` (0 or 1), `rsel` (slave index or ERR) and `rpend`=1.
  - Next cycle the return path muxes `s_rdata_*[rsel]` (or ERR_RDATA) onto the owner's `*_rdata` and pulses the owner's `*_rvalid`.
  - The non-owner's `*_rdata` holds 0.
- Back-to-back reads are fully pipelined: the return for access N and the issue of access N+1 share a cycle with no bubble.
- Writes produce no return and complete in the access cycle.
- Starvation counter (8 bits):
  - Increments each cycle `m1_req`=1 and `m1_gnt`=0.
  - Clears on grant or when `m1_req`=0.
  - On reaching STARVE_MAX it pulses `m1_starve` for one cycle and restarts from 0. Arbitration is unchanged; this is a status indication only.
- Dropping `m1_req` before grant is legal; nothing is issued.

## Timing
- Bus issue is combinational from master inputs. Latency is 0 cycles to the slave strobes and 1 cycle to `*_rvalid`.
- `m1_gnt` is combinational: `m1_req & ~(m0_wr_en|m0_rd_en)`.
- Registered state is limited to `owner`, `rsel`, `rpend` and the starvation counter.
- Reset (asynchronous, may arrive mid-read) clears `rpend`, `owner`, `rsel` and the counter. A read issued in the cycle before reset returns no `rvalid`.
- Reset values: all `*_rvalid`, `*_rdata`, `dec_err` and `m1_starve` are 0. The bus outputs follow their idle values given inputs.

## Structure
- Shared package `trsq8_peri_pkg`: slave base/last address constants (RAM, SPI 0x80/0x83, GPIO 0x84/0x87, IIC 0x90/0x93), slave index constants, and the ERR select encoding.
- Sub-module `peri_addr_decode`: combinational, 8-bit address to 4-bit one-hot select plus error flag. It is reused by any future bus bridge.

## Test plan
- m0 read 0x85 with `s_rdata_gpio`=0x5A: `s_sel`=4'b0100 and `s_rd_en`=1 in T; `m0_rvalid`=1 and `m0_rdata`=0x5A in T+1; `m1_rvalid`=0.
- Collision: `m1_req` (read 0x10) held while m0 writes 0x81 for 3 cycles: `m1_gnt`=0 for those 3 cycles, then 1 in cycle 4; `m1_rdata`=`s_rdata_ram` in cycle 5.
- Pipelined reads: m0 reads 0x90 in cycle T, then m1 is granted a read of 0x20 in T+1. Returns appear in T+1 (m0, IIC data) and T+2 (m1, RAM data), with owners correct.
- Unmapped: m1 reads 0xA0: `dec_err`=1 and `s_sel`=0 in T; `m1_rdata`=0xFF with `m1_rvalid` in T+1.
- Starvation: m0 accesses every cycle and `m1_req` is held. `m1_starve` pulses at wait cycles 64 and 128; once m0 goes idle, `m1_gnt`=1.
- Reset asserted in the return cycle of an m0 read: `m0_rvalid` drops immediately, and no return follows after release.
